piu_dyninfo_ctrl: RTL

Sequencer and arbiter in front of the PIU dynamic patch-info RAM. It accepts boundary-update instructions from the PIU decoder over a valid/ready handshake. Each instruction becomes either a one-cycle bulk strobe (prep/split) or a walk of per-patch writes over a patch bitmask. The single RAM index port is shared between these writes and a read requester (the PIU patch scanner) using alternating priority.

---
 rtl/piu_dyninfo_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/piu_dyninfo_ctrl.sv
// Sequencer/arbiter for the PIU dynamic patch-info RAM: turns decoder instructions
// into bulk strobes or per-patch write walks and shares the RAM index with the scanner.
module piu_dyninfo_ctrl #(
    parameter int NUM_PCH     = 8,
    parameter int PCHADDR_BW  = 3,
    parameter int FACEBD_BW   = 3,
    parameter int CORNERBD_BW = 1,
    localparam int PCHDYN_BW  = 4*FACEBD_BW + 4*CORNERBD_BW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [1:0]               instr_op,
    input  logic [NUM_PCH-1:0]       instr_mask,
    input  logic [4*FACEBD_BW-1:0]   instr_facebd,
    input  logic [4*CORNERBD_BW-1:0] instr_cornerbd,
    output logic                     busy,
    output logic                     done,
    input  logic                     rd_req,
    input  logic [PCHADDR_BW-1:0]    rd_pchidx,
    output logic                     rd_gnt,
    output logic [PCHDYN_BW-1:0]     rd_data,
    output logic                     prep_dyninfo,
    output logic                     split_dyninfo,
    output logic                     is_writing,
    output logic [4*FACEBD_BW-1:0]   wr_facebd,
    output logic [4*CORNERBD_BW-1:0] wr_cornerbd,
    output logic [PCHADDR_BW-1:0]    pchidx,
    input  logic [PCHDYN_BW-1:0]     pchinfo_dynamic
);

    typedef enum logic [1:0] {S_IDLE, S_BULK, S_WALK, S_DONE} state_t;

    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_PREP   = 2'd1;
    localparam logic [1:0] OP_SPLIT  = 2'd2;
    localparam logic [1:0] OP_WRMASK = 2'd3;

    state_t                   state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic [NUM_PCH-1:0]       mask_q, mask_d;
    logic [4*FACEBD_BW-1:0]   facebd_q, facebd_d;
    logic [4*CORNERBD_BW-1:0] cornerbd_q, cornerbd_d;
    logic                     pri_rd_q, pri_rd_d;

    logic [PCHADDR_BW-1:0] wr_target;
    logic [NUM_PCH-1:0]    mask_rest;
    logic                  in_idle, in_bulk, in_walk, in_done;
    logic                  read_wins;

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        wr_target = '0;
        for (int i = NUM_PCH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                wr_target = PCHADDR_BW'(i);
            end
        end
    end

    assign mask_rest = mask_q & (mask_q - NUM_PCH'(1));

    assign in_idle   = (state_q == S_IDLE);
    assign in_bulk   = (state_q == S_BULK);
    assign in_walk   = (state_q == S_WALK);
    assign in_done   = (state_q == S_DONE);
    assign read_wins = rd_req & pri_rd_q;

    assign instr_ready   = in_idle & ~rst;
    assign busy          = ~in_idle & ~rst;
    assign done          = in_done & ~rst;
    assign prep_dyninfo  = ~rst & in_bulk & (op_q == OP_PREP);
    assign split_dyninfo = ~rst & in_bulk & (op_q == OP_SPLIT);
    assign is_writing    = ~rst & in_walk & ~read_wins;
    // Reads are blocked only while a bulk rewrite is in flight or a walk write wins.
    assign rd_gnt        = ~rst & (((in_idle | in_done) & rd_req) | (in_walk & read_wins));

    assign pchidx      = rd_gnt ? rd_pchidx : (is_writing ? wr_target : '0);
    assign rd_data     = rd_gnt ? pchinfo_dynamic : '0;
    assign wr_facebd   = is_writing ? facebd_q : '0;
    assign wr_cornerbd = is_writing ? cornerbd_q : '0;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mask_d     = mask_q;
        facebd_d   = facebd_q;
        cornerbd_d = cornerbd_q;
        pri_rd_d   = pri_rd_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d       = instr_op;
                    mask_d     = instr_mask;
                    facebd_d   = instr_facebd;
                    cornerbd_d = instr_cornerbd;
                    case (instr_op)
                        OP_PREP, OP_SPLIT: state_d = S_BULK;
                        OP_WRMASK:         state_d = (instr_mask != '0) ? S_WALK : S_DONE;
                        OP_NOP:            state_d = S_DONE;
                        default:           state_d = S_DONE;
                    endcase
                end
            end
            S_BULK: state_d = S_DONE;
            S_WALK: begin
                // Priority flips only on contended cycles, giving strict alternation.
                if (rd_req) begin
                    pri_rd_d = ~pri_rd_q;
                end
                if (!read_wins) begin
                    mask_d = mask_rest;
                    if (mask_rest == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            mask_q     <= '0;
            facebd_q   <= '0;
            cornerbd_q <= '0;
            pri_rd_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            facebd_q   <= facebd_d;
            cornerbd_q <= cornerbd_d;
            pri_rd_q   <= pri_rd_d;
        end
    end

endmodule
